cache_refill_ctrl: RTL and testbench

Miss-handling controller for the set-associative caches. On a miss it selects a victim way (first invalid way, else the way named by the replacement-policy generator), writes back the victim if dirty, fetches the line from memory as a fixed-length read burst, writes the assembled line, tag and way into the cache arrays, and pulses the replacement generator's `access`/`update` inputs. It sits between the cache lookup pipeline and the memory interface, and directly consumes `repl_index`.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/victim_sel.sv | 21 ++
 rtl/cache_refill_ctrl.sv | 157 +++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-handling logic: refill FSM states and
// geometry helpers used to size the beat counter and the line offset.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WB,
    ST_AREQ,
    ST_RDATA,
    ST_FILL,
    ST_DONE
  } refill_state_t;

  function automatic int calc_beats(input int line_width, input int data_width);
    return line_width / data_width;
  endfunction

  function automatic int calc_offset_width(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/victim_sel.sv
// Victim way picker: lowest-index invalid way wins, otherwise the way named by
// the replacement policy.
module victim_sel #(
  parameter int SET_ASSOC = 4
) (
  input  logic [SET_ASSOC-1:0]         set_valid,
  input  logic [$clog2(SET_ASSOC)-1:0] repl_index,
  output logic [$clog2(SET_ASSOC)-1:0] victim_way
);

  localparam int WAY_W = $clog2(SET_ASSOC);

  // Scanning from the top down lets the lowest invalid way overwrite any higher one.
  always_comb begin
    victim_way = repl_index;
    for (int i = SET_ASSOC - 1; i >= 0; i--) begin
      if (!set_valid[i]) victim_way = WAY_W'(i);
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller: picks a victim, writes it back if dirty, fetches the
// missing line as a fixed-length burst and writes it into the cache arrays.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int SET_ASSOC   = 4,
  parameter int LINE_WIDTH  = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 32 - INDEX_WIDTH - calc_offset_width(LINE_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_req,
  input  logic [31:0]                     miss_addr,
  input  logic [SET_ASSOC-1:0]            set_valid,
  input  logic [SET_ASSOC-1:0]            set_dirty,
  input  logic [SET_ASSOC*TAG_WIDTH-1:0]  set_tags,
  input  logic [SET_ASSOC*LINE_WIDTH-1:0] set_lines,
  input  logic [$clog2(SET_ASSOC)-1:0]    repl_index,
  output logic [SET_ASSOC-1:0]            repl_access,
  output logic                            repl_update,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [31:0]                     wb_addr,
  output logic [LINE_WIDTH-1:0]           wb_line,
  output logic                            mem_arvalid,
  input  logic                            mem_arready,
  output logic [31:0]                     mem_araddr,
  input  logic                            mem_rvalid,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            fill_we,
  output logic [$clog2(SET_ASSOC)-1:0]    fill_way,
  output logic [INDEX_WIDTH-1:0]          fill_index,
  output logic [TAG_WIDTH-1:0]            fill_tag,
  output logic [LINE_WIDTH-1:0]           fill_line,
  output logic                            refill_done
);

  localparam int WAY_W    = $clog2(SET_ASSOC);
  localparam int BEATS    = calc_beats(LINE_WIDTH, DATA_WIDTH);
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = calc_offset_width(LINE_WIDTH);
  localparam logic [31:0] OFFSET_MASK = 32'((LINE_WIDTH / 8) - 1);

  refill_state_t         state_q, state_d;
  logic [31:0]           araddr_q, araddr_d;
  logic [31:0]           wb_addr_q, wb_addr_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  fill_we_q, fill_we_d;
  logic                  repl_update_q, repl_update_d;
  logic [SET_ASSOC-1:0]  repl_access_q, repl_access_d;
  logic                  refill_done_q, refill_done_d;
  logic [WAY_W-1:0]      sel_way;

  victim_sel #(.SET_ASSOC(SET_ASSOC)) u_victim_sel (
    .set_valid  (set_valid),
    .repl_index (repl_index),
    .victim_way (sel_way)
  );

  // One line buffer serves both as the writeback source and as the refill
  // assembly area; the victim is fully drained before the first read beat lands.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    wb_addr_d = wb_addr_q;
    way_d     = way_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: if (miss_req) state_d = ST_SELECT;
      ST_SELECT: begin
        araddr_d  = miss_addr & ~OFFSET_MASK;
        way_d     = sel_way;
        line_d    = set_lines[sel_way*LINE_WIDTH +: LINE_WIDTH];
        wb_addr_d = {set_tags[sel_way*TAG_WIDTH +: TAG_WIDTH],
                     miss_addr[OFFSET_W +: INDEX_WIDTH], {OFFSET_W{1'b0}}};
        state_d   = (set_valid[sel_way] && set_dirty[sel_way]) ? ST_WB : ST_AREQ;
      end
      ST_WB: if (wb_ready) state_d = ST_AREQ;
      ST_AREQ: begin
        if (mem_arready) begin
          state_d = ST_RDATA;
          cnt_d   = '0;
        end
      end
      ST_RDATA: begin
        if (mem_rvalid) begin
          line_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = ST_FILL;
        end
      end
      ST_FILL: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they are registered yet aligned with it.
    wb_valid_d    = (state_d == ST_WB);
    arvalid_d     = (state_d == ST_AREQ);
    fill_we_d     = (state_d == ST_FILL);
    repl_update_d = (state_d == ST_FILL);
    repl_access_d = (state_d == ST_FILL) ? (SET_ASSOC'(1) << way_d) : '0;
    refill_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      araddr_q      <= '0;
      wb_addr_q     <= '0;
      way_q         <= '0;
      line_q        <= '0;
      cnt_q         <= '0;
      wb_valid_q    <= 1'b0;
      arvalid_q     <= 1'b0;
      fill_we_q     <= 1'b0;
      repl_update_q <= 1'b0;
      repl_access_q <= '0;
      refill_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      araddr_q      <= araddr_d;
      wb_addr_q     <= wb_addr_d;
      way_q         <= way_d;
      line_q        <= line_d;
      cnt_q         <= cnt_d;
      wb_valid_q    <= wb_valid_d;
      arvalid_q     <= arvalid_d;
      fill_we_q     <= fill_we_d;
      repl_update_q <= repl_update_d;
      repl_access_q <= repl_access_d;
      refill_done_q <= refill_done_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_line     = line_q;
  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign fill_we     = fill_we_q;
  assign fill_way    = way_q;
  assign fill_index  = araddr_q[OFFSET_W +: INDEX_WIDTH];
  assign fill_tag    = araddr_q[31 -: TAG_WIDTH];
  assign fill_line   = line_q;
  assign repl_update = repl_update_q;
  assign repl_access = repl_access_q;
  assign refill_done = refill_done_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: a driver issues misses and pushes reference-model
// expectations into queues; a negedge monitor pops and compares them.
module tb_cache_refill_ctrl;

  localparam int SET_ASSOC   = 4;
  localparam int LINE_WIDTH  = 256;
  localparam int DATA_WIDTH  = 32;
  localparam int INDEX_WIDTH = 7;
  localparam int TAG_WIDTH   = 20;
  localparam int BEATS       = LINE_WIDTH / DATA_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic [SET_ASSOC-1:0] set_valid = '0;
  logic [SET_ASSOC-1:0] set_dirty = '0;
  logic [SET_ASSOC*TAG_WIDTH-1:0] set_tags = '0;
  logic [SET_ASSOC*LINE_WIDTH-1:0] set_lines = '0;
  logic [1:0] repl_index = '0;
  logic [SET_ASSOC-1:0] repl_access;
  logic repl_update;
  logic wb_valid;
  logic wb_ready = 1'b0;
  logic [31:0] wb_addr;
  logic [LINE_WIDTH-1:0] wb_line;
  logic mem_arvalid;
  logic mem_arready = 1'b0;
  logic [31:0] mem_araddr;
  logic mem_rvalid = 1'b0;
  logic [DATA_WIDTH-1:0] mem_rdata = '0;
  logic fill_we;
  logic [1:0] fill_way;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [TAG_WIDTH-1:0] fill_tag;
  logic [LINE_WIDTH-1:0] fill_line;
  logic refill_done;

  cache_refill_ctrl #(
    .SET_ASSOC(SET_ASSOC), .LINE_WIDTH(LINE_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .set_valid(set_valid), .set_dirty(set_dirty), .set_tags(set_tags),
    .set_lines(set_lines), .repl_index(repl_index), .repl_access(repl_access),
    .repl_update(repl_update), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_line(wb_line), .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready), .mem_araddr(mem_araddr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_way(fill_way),
    .fill_index(fill_index), .fill_tag(fill_tag), .fill_line(fill_line),
    .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic [LINE_WIDTH-1:0] line;
  } wb_exp_t;

  typedef struct {
    logic [1:0] way;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0] tag;
    logic [LINE_WIDTH-1:0] line;
    logic [SET_ASSOC-1:0] access;
  } fill_exp_t;

  wb_exp_t     wb_q[$];
  logic [31:0] ar_q[$];
  fill_exp_t   fill_q[$];

  task automatic checkOutput(input string name, input logic [LINE_WIDTH-1:0] actual,
                             input logic [LINE_WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic finishTest();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  endtask

  task automatic timeoutFail(input string what);
    checks++;
    fails++;
    $display("[TB] FAIL timeout_%s: got no response, expected one within budget", what);
    finishTest();
  endtask

  // Monitor: pops expectations on the first cycle of each DUT request and keeps
  // comparing while it is held, so any drift before acceptance is caught.
  wb_exp_t   cur_wb;
  logic [31:0] cur_ar;
  fill_exp_t cur_fill;
  bit wb_act = 0, ar_act = 0, fill_pending = 0;

  always @(negedge clk) begin
    if (rst) begin
      wb_act = 0;
      ar_act = 0;
      fill_pending = 0;
    end else begin
      checkOutput("done_after_fill", refill_done, fill_pending);
      fill_pending = 0;
      if (wb_valid) begin
        if (!wb_act) begin
          if (wb_q.size() == 0) checkOutput("unexpected_wb", wb_valid, 0);
          else begin
            cur_wb = wb_q.pop_front();
            wb_act = 1;
          end
        end
        if (wb_act) begin
          checkOutput("wb_addr", wb_addr, cur_wb.addr);
          checkOutput("wb_line", wb_line, cur_wb.line);
          checkOutput("ar_during_wb", mem_arvalid, 0);
        end
      end else wb_act = 0;
      if (mem_arvalid) begin
        if (!ar_act) begin
          if (ar_q.size() == 0) checkOutput("unexpected_ar", mem_arvalid, 0);
          else begin
            cur_ar = ar_q.pop_front();
            ar_act = 1;
          end
        end
        if (ar_act) checkOutput("mem_araddr", mem_araddr, cur_ar);
      end else ar_act = 0;
      if (fill_we) begin
        if (fill_q.size() == 0) checkOutput("unexpected_fill", fill_we, 0);
        else begin
          cur_fill = fill_q.pop_front();
          checkOutput("fill_way", fill_way, cur_fill.way);
          checkOutput("fill_index", fill_index, cur_fill.index);
          checkOutput("fill_tag", fill_tag, cur_fill.tag);
          checkOutput("fill_line", fill_line, cur_fill.line);
          checkOutput("repl_access", repl_access, cur_fill.access);
          checkOutput("repl_update", repl_update, 1);
          fill_pending = 1;
        end
      end else begin
        checkOutput("idle_repl_update", repl_update, 0);
        checkOutput("idle_repl_access", repl_access, 0);
      end
    end
  end

  // Issues one miss, computes the expected outcome from the victim rules and
  // the burst data, then plays the memory/writeback side of the handshake.
  task automatic applyStimulus(
    input logic [31:0] addr, input logic [3:0] valid, input logic [3:0] dirty,
    input logic [1:0] repl, input logic [SET_ASSOC*TAG_WIDTH-1:0] tags,
    input logic [SET_ASSOC*LINE_WIDTH-1:0] lines, input int wb_delay,
    input int ar_delay, input bit gaps, input bit fixed_beats, input bit early_drop,
    input int abort_after, output int latency);
    logic [31:0] beat [BEATS];
    logic [LINE_WIDTH-1:0] exp_line;
    wb_exp_t we;
    fill_exp_t fe;
    int v, n, start;
    bit exp_wb;

    latency = 0;
    v = -1;
    for (int i = 0; i < SET_ASSOC; i++) if (v < 0 && !valid[i]) v = i;
    if (v < 0) v = int'(repl);
    exp_wb = valid[v] && dirty[v];
    for (int b = 0; b < BEATS; b++) begin
      beat[b] = fixed_beats ? 32'(b) : $urandom();
      exp_line[b*DATA_WIDTH +: DATA_WIDTH] = beat[b];
    end
    if (exp_wb) begin
      we.addr = {tags[v*TAG_WIDTH +: TAG_WIDTH], addr[11:5], 5'b0};
      we.line = lines[v*LINE_WIDTH +: LINE_WIDTH];
      wb_q.push_back(we);
    end
    ar_q.push_back(addr & 32'hFFFF_FFE0);
    if (abort_after < 0) begin
      fe.way = 2'(v);
      fe.index = addr[11:5];
      fe.tag = addr[31:12];
      fe.line = exp_line;
      fe.access = '0;
      fe.access[v] = 1'b1;
      fill_q.push_back(fe);
    end

    @(posedge clk); #1;
    miss_addr = addr; set_valid = valid; set_dirty = dirty; repl_index = repl;
    set_tags = tags; set_lines = lines; miss_req = 1'b1;
    start = cyc;

    if (exp_wb) begin
      n = 0;
      while (!wb_valid && n < 20) begin @(posedge clk); #1; n++; end
      if (!wb_valid) timeoutFail("wb_valid");
      repeat (wb_delay) begin
        mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom();
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0; wb_ready = 1'b1;
      @(posedge clk); #1;
      wb_ready = 1'b0;
    end

    n = 0;
    while (!mem_arvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!mem_arvalid) timeoutFail("mem_arvalid");
    for (int i = 0; i < ar_delay; i++) begin
      checkOutput("arvalid_held", mem_arvalid, 1);
      mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom();
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0; mem_arready = 1'b1;
    @(posedge clk); #1;
    mem_arready = 1'b0;
    if (early_drop) miss_req = 1'b0;

    for (int b = 0; b < BEATS; b++) begin
      if (abort_after == b) begin
        mem_rvalid = 1'b0; miss_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_fill_we", fill_we, 0);
        checkOutput("rst_arvalid", mem_arvalid, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_refill_done", refill_done, 0);
        checkOutput("rst_fill_line", fill_line, 0);
        checkOutput("rst_araddr", mem_araddr, 0);
        return;
      end
      if (gaps) repeat ($urandom_range(0, 2)) begin
        mem_rvalid = 1'b0; mem_rdata = $urandom();
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1; mem_rdata = beat[b];
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;

    n = 0;
    while (!refill_done && n < 20) begin @(posedge clk); #1; n++; end
    if (!refill_done) timeoutFail("refill_done");
    latency = cyc - start;
    miss_req = 1'b0;
  endtask

  function automatic logic [SET_ASSOC*LINE_WIDTH-1:0] randomLines();
    logic [SET_ASSOC*LINE_WIDTH-1:0] l;
    for (int w = 0; w < SET_ASSOC*LINE_WIDTH/32; w++) l[w*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [SET_ASSOC*TAG_WIDTH-1:0] randomTags();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    timeoutFail("global");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_wb_valid", wb_valid, 0);
    checkOutput("reset_arvalid", mem_arvalid, 0);
    checkOutput("reset_fill_we", fill_we, 0);
    checkOutput("reset_refill_done", refill_done, 0);
    checkOutput("reset_repl_update", repl_update, 0);
    checkOutput("reset_repl_access", repl_access, 0);
    checkOutput("reset_fill_line", fill_line, 0);
    checkOutput("reset_fill_way", fill_way, 0);

    // First-invalid victim (way 2) beats repl_index; invalid-but-dirty must not write back.
    applyStimulus(32'h0000_4A40, 4'b1011, 4'b1111, 2'd3, randomTags(), randomLines(),
                  0, 0, 0, 0, 0, -1, lat);
    checkOutput("min_latency_clean", lat, 12);

    // All valid, way 1 dirty: writeback to {0x12345, 5, 0} before the burst.
    applyStimulus({20'hABCDE, 7'd5, 5'h0C}, 4'b1111, 4'b0010, 2'd1,
                  {20'h11111, 20'h22222, 20'h12345, 20'h33333}, randomLines(),
                  3, 0, 0, 0, 0, -1, lat);

    applyStimulus(32'h0000_2000, 4'b1111, 4'b0000, 2'd0, randomTags(), randomLines(),
                  0, 0, 1, 1, 0, -1, lat);

    applyStimulus(32'h8765_4320, 4'b0111, 4'b0000, 2'd2, randomTags(), randomLines(),
                  0, 10, 0, 0, 0, -1, lat);

    applyStimulus(32'h0000_1F7C, 4'b1111, 4'b0000, 2'd2, randomTags(), randomLines(),
                  0, 0, 0, 0, 0, -1, lat);

    applyStimulus(32'hCAFE_0440, 4'b1111, 4'b1111, 2'd3, randomTags(), randomLines(),
                  1, 0, 0, 0, 0, 3, lat);
    applyStimulus(32'hCAFE_0440, 4'b1110, 4'b0000, 2'd3, randomTags(), randomLines(),
                  0, 0, 1, 1, 0, -1, lat);

    for (int t = 0; t < 25; t++) begin
      applyStimulus($urandom(), 4'($urandom()), 4'($urandom()), 2'($urandom()),
                    randomTags(), randomLines(), $urandom_range(0, 4),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0,
                    1'($urandom_range(0, 1)), -1, lat);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("wb_queue_drained", wb_q.size(), 0);
    checkOutput("ar_queue_drained", ar_q.size(), 0);
    checkOutput("fill_queue_drained", fill_q.size(), 0);
    finishTest();
  end

endmodule
